// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a byte stream in preamble/SFD, optional pad + CRC-32 FCS, and an inter-frame gap.
// Optional feature macro GMII_TX_CRC_EN enables the PAD/FCS path; without it the user supplies the FCS in the payload.
module gmii_tx_framer #(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_tdata,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       busy
);

  if (IFG_BYTES < 1 || IFG_BYTES > 255 || MIN_PAYLOAD < 0 || MIN_PAYLOAD > 2047) begin : g_bad_param
    $error("gmii_tx_framer: IFG_BYTES must be 1..255 and MIN_PAYLOAD 0..2047");
  end

  localparam logic [7:0] IFG_LOAD = 8'(IFG_BYTES - 1);

  // state | meaning: IDLE wait for data | PREAMBLE 0x55 bytes | SFD 0xD5 | DATA payload |
  // PAD zero fill | FCS CRC bytes | IFG idle gap | DRAIN discard after underrun
`ifdef GMII_TX_CRC_EN
  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_IFG, S_DRAIN
  } state_t;
`endif

  state_t      state_q;
  logic [7:0]  timer_q;
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        tx_er_q;

`ifdef GMII_TX_CRC_EN
  localparam logic [31:0] CRC_POLY  = 32'hEDB8_8320;
  localparam logic [10:0] MIN_PAY_C = 11'(MIN_PAYLOAD);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [10:0] cnt_q;
  logic [10:0] cnt_inc;
  logic [31:0] fcs;
  logic [7:0]  fcs_byte;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  always_comb begin
    crc_d   = crc32_byte(crc_q, (state_q == S_PAD) ? 8'h00 : s_tdata);
    cnt_inc = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
    fcs     = ~crc_q;
    // timer counts 3..0 through FCS, so byte 0 (LSB) leaves first
    case (timer_q[1:0])
      2'd3:    fcs_byte = fcs[7:0];
      2'd2:    fcs_byte = fcs[15:8];
      2'd1:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      txd_q   <= '0;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
`ifdef GMII_TX_CRC_EN
      crc_q   <= '1;
      cnt_q   <= '0;
`endif
    end else begin
      tx_er_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          if (s_tvalid) begin
            // first preamble byte is launched on the way out of IDLE
            txd_q   <= 8'h55;
            tx_en_q <= 1'b1;
            timer_q <= 8'd5;
            state_q <= S_PREAMBLE;
          end
        end
        S_PREAMBLE: begin
          txd_q   <= 8'h55;
          tx_en_q <= 1'b1;
          if (timer_q == 8'd0) state_q <= S_SFD;
          else                 timer_q <= timer_q - 8'd1;
        end
        S_SFD: begin
          txd_q   <= 8'hD5;
          tx_en_q <= 1'b1;
          state_q <= S_DATA;
`ifdef GMII_TX_CRC_EN
          crc_q   <= '1;
          cnt_q   <= '0;
`endif
        end
        S_DATA: begin
          tx_en_q <= 1'b1;
          if (s_tvalid) begin
            txd_q <= s_tdata;
`ifdef GMII_TX_CRC_EN
            crc_q <= crc_d;
            cnt_q <= cnt_inc;
            if (s_tlast) begin
              if (cnt_inc < MIN_PAY_C) begin
                state_q <= S_PAD;
              end else begin
                timer_q <= 8'd3;
                state_q <= S_FCS;
              end
            end
`else
            if (s_tlast) begin
              timer_q <= IFG_LOAD;
              state_q <= S_IFG;
            end
`endif
          end else begin
            txd_q   <= 8'h00;
            tx_er_q <= 1'b1;
            state_q <= S_DRAIN;
          end
        end
`ifdef GMII_TX_CRC_EN
        S_PAD: begin
          txd_q   <= 8'h00;
          tx_en_q <= 1'b1;
          crc_q   <= crc_d;
          cnt_q   <= cnt_inc;
          if (cnt_inc >= MIN_PAY_C) begin
            timer_q <= 8'd3;
            state_q <= S_FCS;
          end
        end
        S_FCS: begin
          txd_q   <= fcs_byte;
          tx_en_q <= 1'b1;
          if (timer_q == 8'd0) begin
            timer_q <= IFG_LOAD;
            state_q <= S_IFG;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
`endif
        S_IFG: begin
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          if (timer_q == 8'd0) state_q <= S_IDLE;
          else                 timer_q <= timer_q - 8'd1;
        end
        S_DRAIN: begin
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          if (s_tvalid && s_tlast) begin
            timer_q <= IFG_LOAD;
            state_q <= S_IFG;
          end
        end
        default: begin
          txd_q   <= 8'h00;
          tx_en_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign s_tready   = (state_q == S_DATA) || (state_q == S_DRAIN);
  assign busy       = (state_q != S_IDLE);
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = tx_en_q;
  assign gmii_tx_er = tx_er_q;

endmodule
